sparse_result_tx: RTL and testbench

Result-return transmitter for the sparse matrix coprocessor. It buffers FPU results (value, element index, status flags), frames each one as a 6-byte packet, and sends the packets byte by byte through the `comm` UART transmitter using its `TxD_start`/`TxD_busy` handshake. It is the coprocessor-to-host direction of the serial link whose receive side loads operands.

---
 rtl/sparse_result_tx.sv | 122 ++++++++++++
 tb/tb_sparse_result_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_result_tx.sv
// Result-return transmitter: buffers FPU results in a small FIFO and sends each one
// to the host as a 6-byte packet through the comm UART start/busy handshake.
module sparse_result_tx #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [15:0]              res_data,
  input  logic [7:0]               res_index,
  input  logic [3:0]               res_flags,
  output logic [7:0]               TxD_data,
  output logic                     TxD_start,
  input  logic                     TxD_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_done,
  output logic                     tx_active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DONE} state_t;

  state_t          state;
  logic [27:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [5:0][7:0] frame;
  logic [2:0]      n;
  logic [2:0]      n_next;
  logic            push;
  logic            pop;
  logic [27:0]     head;
  logic [7:0]      b1;
  logic [7:0]      b2;
  logic [7:0]      b3;
  logic [7:0]      b4;

  assign res_ready  = (count != FULL);
  assign push       = res_valid && res_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];
  assign b1         = head[27:20];
  assign b2         = head[19:12];
  assign b3         = head[11:4];
  assign b4         = {4'b0000, head[3:0]};
  assign n_next     = n + 3'd1;
  assign fifo_count = count;
  assign tx_active  = (state != IDLE);

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {res_index, res_data, res_flags};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Start pulses are loaded together with the byte so TxD_data is stable for the whole byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      n          <= '0;
      frame      <= '0;
      TxD_data   <= 8'h00;
      TxD_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      TxD_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            frame     <= {b1 ^ b2 ^ b3 ^ b4, b4, b3, b2, b1, SYNC};
            n         <= '0;
            TxD_data  <= SYNC;
            TxD_start <= 1'b1;
            state     <= START;
          end
        end
        START:   state <= WAIT_HI;
        WAIT_HI: if (TxD_busy) state <= WAIT_LO;
        WAIT_LO: begin
          if (!TxD_busy) begin
            if (n == 3'd5) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              n         <= n_next;
              TxD_data  <= frame[n_next];
              TxD_start <= 1'b1;
              state     <= START;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_result_tx.sv
// Directed bench for sparse_result_tx with a behavioural comm transmitter that
// records every launched byte, start cycle and frame_done pulse.
module tb_sparse_result_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [15:0] res_data = '0;
  logic [7:0]  res_index = '0;
  logic [3:0]  res_flags = '0;
  logic [7:0]  TxD_data;
  logic        TxD_start;
  logic        TxD_busy = 1'b0;
  logic [2:0]  fifo_count;
  logic        frame_done;
  logic        tx_active;

  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [7:0]  bytes_q[$];
  int          start_cyc[$];
  int          done_cyc[$];
  bit          imm_busy = 1'b0;
  int          busy_hold = 10;
  int          busy_left = 0;
  bit          pend = 1'b0;

  sparse_result_tx #(.DEPTH(4), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_index(res_index), .res_flags(res_flags),
    .TxD_data(TxD_data), .TxD_start(TxD_start), .TxD_busy(TxD_busy),
    .fifo_count(fifo_count), .frame_done(frame_done), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  // comm model: busy rises in the start cycle (imm_busy) or the cycle after, for busy_hold cycles.
  always @(negedge clk) begin
    cyc++;
    if (frame_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (TxD_start) begin
      bytes_q.push_back(TxD_data);
      start_cyc.push_back(cyc);
      if (imm_busy) begin
        TxD_busy  = 1'b1;
        busy_left = busy_hold;
      end else begin
        pend = 1'b1;
      end
    end else if (pend) begin
      pend      = 1'b0;
      TxD_busy  = 1'b1;
      busy_left = busy_hold;
    end else if (TxD_busy) begin
      busy_left--;
      if (busy_left <= 0) TxD_busy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [47:0] expFrame(input logic [7:0] idx, input logic [15:0] d,
                                           input logic [3:0] f);
    logic [7:0] ck;
    ck = idx ^ d[15:8] ^ d[7:0] ^ {4'h0, f};
    return {8'hA5, idx, d[15:8], d[7:0], {4'h0, f}, ck};
  endfunction

  function automatic logic [47:0] gotFrame(input int base);
    logic [47:0] r;
    r = 'x;
    if (bytes_q.size() >= base + 6)
      for (int i = 0; i < 6; i++) r[47-8*i -: 8] = bytes_q[base+i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] idx, input logic [15:0] d,
                               input logic [3:0] f, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    res_valid = 1'b1;
    res_index = idx;
    res_data  = d;
    res_flags = f;
    while (!res_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_accept"}, 48'(res_ready), 48'd1);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_frames_done"}, 48'(done_cnt >= target), 48'd1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int base;
    int dbase;
    int snap;
    int k;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_start", 48'(TxD_start), 48'd0);
    checkOutput("rst_data", 48'(TxD_data), 48'h00);
    checkOutput("rst_done", 48'(frame_done), 48'd0);
    checkOutput("rst_active", 48'(tx_active), 48'd0);
    checkOutput("rst_count", 48'(fifo_count), 48'd0);
    checkOutput("rst_ready", 48'(res_ready), 48'd1);
    reset = 1'b0;

    // Single packet, busy held 10 cycles, first-byte latency
    busy_hold = 10;
    base = bytes_q.size();
    dbase = done_cnt;
    applyStimulus(8'h07, 16'h3C00, 4'b0000, "single");
    checkOutput("lat_count_after_push", 48'(fifo_count), 48'd1);
    checkOutput("lat_no_start_yet", 48'(TxD_start), 48'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_start", 48'(TxD_start), 48'd1);
    checkOutput("lat_sync", 48'(TxD_data), 48'hA5);
    checkOutput("lat_count_popped", 48'(fifo_count), 48'd0);
    checkOutput("lat_active", 48'(tx_active), 48'd1);
    waitDone(dbase + 1, 1000, "single");
    checkOutput("single_frame", gotFrame(base), 48'hA5073C00003B);
    checkOutput("single_starts", 48'(bytes_q.size() - base), 48'd6);
    checkOutput("single_done_pulses", 48'(done_cnt - dbase), 48'd1);
    checkOutput("single_idle", 48'(tx_active), 48'd0);

    // Checksum with flags, back-to-back frames
    base = bytes_q.size();
    dbase = done_cnt;
    applyStimulus(8'h12, 16'hABCD, 4'b0001, "ck1");
    applyStimulus(8'h12, 16'hABCD, 4'b1000, "ck2");
    waitDone(dbase + 2, 1000, "ck");
    checkOutput("ck_frame_ovf", gotFrame(base), 48'hA512ABCD0175);
    checkOutput("ck_frame_nan", gotFrame(base + 6), 48'hA512ABCD087C);
    checkOutput("ck_frame_gap", 48'(start_cyc[base+6] - done_cyc[dbase]), 48'd2);

    // Fill and backpressure
    busy_hold = 20;
    base = bytes_q.size();
    dbase = done_cnt;
    for (int i = 0; i < 5; i++)
      applyStimulus(8'(8'h40 + i), 16'(16'h1111 * (i + 1)), 4'(i), "fill");
    checkOutput("fill_count_full", 48'(fifo_count), 48'd4);
    checkOutput("fill_ready_low", 48'(res_ready), 48'd0);
    applyStimulus(8'h45, 16'h6666, 4'd5, "fill_last");
    checkOutput("fill_count_refill", 48'(fifo_count), 48'd4);
    waitDone(dbase + 6, 3000, "fill");
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("fill_frame%0d", i), gotFrame(base + 6*i),
                  expFrame(8'(8'h40 + i), 16'(16'h1111 * (i + 1)), 4'(i)));

    // Simultaneous push and pop with two entries stored
    busy_hold = 8;
    base = bytes_q.size();
    dbase = done_cnt;
    for (int i = 0; i < 3; i++)
      applyStimulus(8'(8'h60 + i), 16'(16'hA0B0 + i), 4'(i + 2), "pp");
    k = 0;
    while (!frame_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("pp_saw_done", 48'(frame_done), 48'd1);
    checkOutput("pp_count_before", 48'(fifo_count), 48'd2);
    applyStimulus(8'h63, 16'hA0B3, 4'd5, "pp_sim");
    checkOutput("pp_count_after", 48'(fifo_count), 48'd2);
    checkOutput("pp_start", 48'(TxD_start), 48'd1);
    waitDone(dbase + 4, 2000, "pp");
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("pp_frame%0d", i), gotFrame(base + 6*i),
                  expFrame(8'(8'h60 + i), 16'(16'hA0B0 + i), 4'(i + 2)));

    // Reset during WAIT_LO of byte 3 with another word queued
    busy_hold = 10;
    base = bytes_q.size();
    dbase = done_cnt;
    applyStimulus(8'h33, 16'h4455, 4'd2, "rm1");
    applyStimulus(8'h34, 16'h5566, 4'd3, "rm2");
    k = 0;
    while (bytes_q.size() < base + 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rm_reached_byte3", 48'(bytes_q.size() >= base + 4), 48'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rm_start", 48'(TxD_start), 48'd0);
    checkOutput("rm_data", 48'(TxD_data), 48'h00);
    checkOutput("rm_done", 48'(frame_done), 48'd0);
    checkOutput("rm_active", 48'(tx_active), 48'd0);
    checkOutput("rm_count", 48'(fifo_count), 48'd0);
    checkOutput("rm_ready", 48'(res_ready), 48'd1);
    @(negedge clk);
    reset = 1'b0;
    snap = bytes_q.size();
    repeat (60) @(negedge clk);
    checkOutput("rm_no_new_starts", 48'(bytes_q.size()), 48'(snap));
    checkOutput("rm_no_done", 48'(done_cnt), 48'(dbase));
    checkOutput("rm_still_idle", 48'(tx_active), 48'd0);

    // Busy raised in the start cycle, one cycle beyond it
    imm_busy = 1'b1;
    busy_hold = 2;
    base = bytes_q.size();
    dbase = done_cnt;
    applyStimulus(8'h5A, 16'h1234, 4'b0100, "imm");
    waitDone(dbase + 1, 500, "imm");
    checkOutput("imm_frame", gotFrame(base), 48'hA55A12340478);
    checkOutput("imm_starts", 48'(bytes_q.size() - base), 48'd6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
